// File: rtl/lmfe_pkg.sv
// rtl/lmfe_pkg.sv - shared geometry, state encoding and line-buffer slot helper for the median filter engine
package lmfe_pkg;

    localparam int IMG_W   = 128;
    localparam int IMG_H   = 128;
    localparam int WIN     = 7;
    localparam int RAD     = (WIN - 1) / 2;
    localparam int DW      = 8;
    localparam int NWIN    = WIN * WIN;
    localparam int MED_IDX = 24;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } lmfe_state_e;

    // Line-buffer slot holding a given image row.
    function automatic logic [2:0] row_slot(input logic [7:0] row);
        return 3'(row % 8'(WIN));
    endfunction

endpackage

// File: rtl/lmfe_line_buf.sv
// rtl/lmfe_line_buf.sv - single-port circular line buffer, synchronous write, registered read
module lmfe_line_buf
    import lmfe_pkg::*;
#(
    parameter int DEPTH = WIN * IMG_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/lmfe.sv
// rtl/lmfe.sv - streaming 7x7 zero-padded median filter, one sorted-array slide per output pixel
module lmfe
    import lmfe_pkg::*;
#(
    parameter int COLS = IMG_W,
    parameter int ROWS = IMG_H
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] Din,
    input  logic          in_en,
    output logic          busy,
    output logic          out_valid,
    output logic [DW-1:0] Dout
);

    localparam int DEPTH = WIN * COLS;
    localparam int AW    = $clog2(DEPTH);

    lmfe_state_e   state_q, state_d;
    logic [7:0]    in_row_q, in_row_d;
    logic [7:0]    in_col_q, in_col_d;
    logic [7:0]    out_row_q, out_row_d;
    logic [7:0]    cx_q, cx_d;
    logic [3:0]    step_q, step_d;
    logic          op_valid_q, op_valid_d;
    logic          op_del_q, op_del_d;
    logic          op_pad_q, op_pad_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] sorted_q [NWIN];
    logic [DW-1:0] sorted_d [NWIN];

    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_rdata;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [2:0]    elem_k;
    logic [7:0]    row_p;
    logic [7:0]    col_sel;
    logic          row_ok;
    logic          col_ok;
    logic [DW-1:0] elem_v;

    lmfe_line_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .addr  (buf_addr),
        .wdata (Din),
        .rdata (buf_rdata)
    );

    // cx is the column being inserted (c+RAD); steps 0..6 fetch the leaving column cx-WIN, 7..13 the entering one.
    assign elem_k  = (step_q < 4'd7) ? step_q[2:0] : 3'(step_q - 4'd7);
    assign row_p   = out_row_q + {5'd0, elem_k};
    assign row_ok  = (row_p >= 8'(RAD)) && (row_p < 8'(ROWS + RAD));
    assign col_sel = (step_q < 4'd7) ? (cx_q - 8'(WIN)) : cx_q;
    assign col_ok  = (step_q < 4'd7) ? (cx_q >= 8'(WIN)) : (cx_q < 8'(COLS));
    assign rd_addr = (row_ok && col_ok)
                   ? AW'(int'(row_slot(row_p - 8'(RAD))) * COLS + int'(col_sel)) : '0;
    assign wr_addr = AW'(int'(row_slot(in_row_q)) * COLS + int'(in_col_q));
    assign elem_v  = op_pad_q ? '0 : buf_rdata;

    always_comb begin
        state_d     = state_q;
        in_row_d    = in_row_q;
        in_col_d    = in_col_q;
        out_row_d   = out_row_q;
        cx_d        = cx_q;
        step_d      = step_q;
        op_valid_d  = 1'b0;
        op_del_d    = op_del_q;
        op_pad_d    = op_pad_q;
        out_valid_d = 1'b0;
        dout_d      = dout_q;
        sorted_d    = sorted_q;
        buf_we      = 1'b0;
        buf_addr    = rd_addr;

        // Top slot refills with all-ones after a delete so the following inserts can treat it as +infinity.
        if (op_valid_q) begin
            if (op_del_q) begin
                for (int i = 0; i < NWIN - 1; i++) begin
                    sorted_d[i] = (sorted_q[i] < elem_v) ? sorted_q[i] : sorted_q[i+1];
                end
                sorted_d[NWIN-1] = '1;
            end else begin
                sorted_d[0] = (sorted_q[0] <= elem_v) ? sorted_q[0] : elem_v;
                for (int i = 1; i < NWIN; i++) begin
                    sorted_d[i] = (sorted_q[i] <= elem_v) ? sorted_q[i]
                                : ((sorted_q[i-1] <= elem_v) ? elem_v : sorted_q[i-1]);
                end
            end
        end

        unique case (state_q)
            FILL: begin
                if (in_en) begin
                    buf_we   = 1'b1;
                    buf_addr = wr_addr;
                    if (in_col_q == 8'(COLS - 1)) begin
                        in_col_d = '0;
                        in_row_d = in_row_q + 8'd1;
                    end else begin
                        in_col_d = in_col_q + 8'd1;
                    end
                end
                if ((in_row_d >= out_row_q + 8'(RAD + 1)) || (in_row_d == 8'(ROWS))) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (step_q <= 4'd13) begin
                    op_valid_d = 1'b1;
                    op_del_d   = (step_q < 4'd7);
                    op_pad_d   = !(row_ok && col_ok);
                    step_d     = step_q + 4'd1;
                end else if (step_q == 4'd14) begin
                    step_d = 4'd15;
                end else begin
                    step_d = '0;
                    if (cx_q >= 8'(RAD)) begin
                        out_valid_d = 1'b1;
                        dout_d      = sorted_q[MED_IDX];
                    end
                    if (cx_q == 8'(COLS + RAD - 1)) begin
                        cx_d      = '0;
                        out_row_d = out_row_q + 8'd1;
                        for (int i = 0; i < NWIN; i++) begin
                            sorted_d[i] = '0;
                        end
                        if (out_row_q == 8'(ROWS - 1)) begin
                            state_d = DONE;
                        end else if (in_row_q != 8'(ROWS)) begin
                            state_d = FILL;
                        end
                    end else begin
                        cx_d = cx_q + 8'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            in_row_q    <= '0;
            in_col_q    <= '0;
            out_row_q   <= '0;
            cx_q        <= '0;
            step_q      <= '0;
            op_valid_q  <= 1'b0;
            op_del_q    <= 1'b0;
            op_pad_q    <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            for (int i = 0; i < NWIN; i++) begin
                sorted_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            in_row_q    <= in_row_d;
            in_col_q    <= in_col_d;
            out_row_q   <= out_row_d;
            cx_q        <= cx_d;
            step_q      <= step_d;
            op_valid_q  <= op_valid_d;
            op_del_q    <= op_del_d;
            op_pad_q    <= op_pad_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            sorted_q    <= sorted_d;
        end
    end

    assign busy      = (state_q != FILL);
    assign out_valid = out_valid_q;
    assign Dout      = dout_q;

endmodule

// File: tb/tb_lmfe.sv
// tb/tb_lmfe.sv - scoreboard bench for lmfe on a reduced 16x16 frame geometry
module tb_lmfe;
    import lmfe_pkg::*;

    localparam int TW   = 16;
    localparam int TH   = 16;
    localparam int NPIX = TW * TH;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       in_en = 1'b0;
    logic       busy;
    logic       out_valid;
    logic [7:0] dout;

    logic [7:0] frame [NPIX];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         out_cnt = 0;
    bit         ignore_out = 1'b0;

    always #5 clk = ~clk;

    lmfe #(.COLS(TW), .ROWS(TH)) dut (
        .clk       (clk),
        .reset     (reset),
        .Din       (din),
        .in_en     (in_en),
        .busy      (busy),
        .out_valid (out_valid),
        .Dout      (dout)
    );

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic logic [7:0] pix(input int r, input int c);
        if (r < 0 || r >= TH || c < 0 || c >= TW) return 8'h00;
        return frame[r*TW + c];
    endfunction

    function automatic logic [7:0] model_med(input int r, input int c);
        logic [7:0] v [NWIN];
        logic [7:0] t;
        int n;
        n = 0;
        for (int dr = -RAD; dr <= RAD; dr++) begin
            for (int dc = -RAD; dc <= RAD; dc++) begin
                v[n] = pix(r + dr, c + dc);
                n++;
            end
        end
        for (int i = 0; i < NWIN - 1; i++) begin
            for (int j = 0; j < NWIN - 1 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        return v[MED_IDX];
    endfunction

    // mode 0: model, 1: constant 0xC8 (window count rule), 2: impulse (interior forced to 0x40)
    task automatic push_expected(input int mode);
        int n;
        out_cnt = 0;
        for (int r = 0; r < TH; r++) begin
            for (int c = 0; c < TW; c++) begin
                if (mode == 1) begin
                    n = 0;
                    for (int dr = -RAD; dr <= RAD; dr++)
                        for (int dc = -RAD; dc <= RAD; dc++)
                            if (r+dr >= 0 && r+dr < TH && c+dc >= 0 && c+dc < TW) n++;
                    exp_q.push_back((n >= 25) ? 8'hC8 : 8'h00);
                end else if (mode == 2 && r >= RAD && r < TH-RAD && c >= RAD && c < TW-RAD) begin
                    exp_q.push_back(8'h40);
                end else begin
                    exp_q.push_back(model_med(r, c));
                end
            end
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && !ignore_out) begin
                out_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got %02h want none", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        errors++;
                        $display("FAIL pixel_%0d got %02h want %02h", out_cnt - 1, dout, e);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send(input int npix, input bit throttle);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < npix) begin
            @(negedge clk);
            cyc++;
            if (cyc > 40000) begin
                $display("FAIL send_timeout got %0d want %0d", i, npix);
                errors++;
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "input stalled");
            end
            if (busy) begin
                in_en = throttle ? 1'($urandom_range(0, 1)) : 1'b0;
                din   = 8'hEE;
            end else if (throttle && $urandom_range(0, 1) == 0) begin
                in_en = 1'b0;
                din   = 8'h5A;
            end else begin
                in_en = 1'b1;
                din   = frame[i];
                i++;
            end
        end
        @(negedge clk);
        in_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, int'(exp_q.size() == 0), 1);
        repeat (40) @(negedge clk);
        check({name, "_count"}, out_cnt, NPIX);
        check({name, "_busy_done"}, int'(busy), 1);
    endtask

    initial begin
        fork
            monitor();
        join_none

        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_dout", int'(dout), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NPIX; i++) frame[i] = 8'h00;
        push_expected(0);
        send(NPIX, 1'b0);
        drain("zero");
        in_en = 1'b1;
        din   = 8'h77;
        repeat (20) @(negedge clk);
        in_en = 1'b0;
        check("done_ignores_busy", int'(busy), 1);
        check("done_ignores_count", out_cnt, NPIX);

        do_reset();
        for (int i = 0; i < NPIX; i++) frame[i] = 8'hC8;
        push_expected(1);
        send(NPIX, 1'b0);
        drain("const");

        do_reset();
        for (int i = 0; i < NPIX; i++) frame[i] = 8'($urandom_range(0, 255));
        push_expected(0);
        send(NPIX, 1'b0);
        drain("random");

        do_reset();
        push_expected(0);
        send(NPIX, 1'b1);
        drain("throttled");

        do_reset();
        for (int i = 0; i < NPIX; i++) frame[i] = ((i % 11) == 5) ? 8'hFF : 8'h40;
        push_expected(2);
        send(NPIX, 1'b0);
        drain("impulse");

        do_reset();
        for (int i = 0; i < NPIX; i++) frame[i] = 8'($urandom_range(0, 255));
        ignore_out = 1'b1;
        send(150, 1'b0);
        repeat (3) @(negedge clk);
        do_reset();
        ignore_out = 1'b0;
        out_cnt = 0;
        repeat (100) @(negedge clk);
        check("abort_quiet_count", out_cnt, 0);
        check("abort_busy", int'(busy), 0);
        push_expected(0);
        send(NPIX, 1'b0);
        drain("abort_resend");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
